bias_sram_ctrl: RTL and testbench

BIAS_SRAM_CTRL -- requirements
Module: bias_sram_ctrl

---
 rtl/bias_ctrl_pkg.sv | 14 +
 rtl/bias_sram_ctrl_if.sv | 28 ++
 rtl/bias_sram_ctrl.sv | 114 +++++++++++
 tb/tb_bias_sram_ctrl.sv | 379 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bias_ctrl_pkg.sv
// Shared constants and FSM state encoding for the bias SRAM controller.
package bias_ctrl_pkg;

    localparam int WORDS = 48;
    localparam int BITW  = 17;
    localparam int AW    = $clog2(WORDS);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        READY = 2'd2
    } state_t;

endpackage

// File: rtl/bias_sram_ctrl_if.sv
// Bias load stream, fetch request and read response bundle between a client and bias_sram_ctrl.
interface bias_sram_ctrl_if #(
    parameter int AW   = bias_ctrl_pkg::AW,
    parameter int BITW = bias_ctrl_pkg::BITW
) ();

    logic            ld_valid;
    logic [BITW-1:0] ld_data;
    logic            ld_ready;

    logic            fetch_req;
    logic [AW-1:0]   fetch_ch;
    logic            fetch_gnt;

    logic            bias_valid;
    logic [BITW-1:0] bias_data;

    modport master (
        output ld_valid, ld_data, fetch_req, fetch_ch,
        input  ld_ready, fetch_gnt, bias_valid, bias_data
    );

    modport slave (
        input  ld_valid, ld_data, fetch_req, fetch_ch,
        output ld_ready, fetch_gnt, bias_valid, bias_data
    );

endinterface

// File: rtl/bias_sram_ctrl.sv
// Bias SRAM controller: loads a bias table into an external single-port SRAM,
// then serves per-channel fetches with a one-cycle registered-read response.
module bias_sram_ctrl #(
    parameter  int WORDS = bias_ctrl_pkg::WORDS,
    parameter  int BITW  = bias_ctrl_pkg::BITW,
    localparam int AW    = $clog2(WORDS)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load_start,
    input  logic [AW-1:0]   load_len,
    bias_sram_ctrl_if.slave bus,
    output logic            busy,
    output logic            loaded,
    output logic            err,
    output logic            sram_we,
    output logic [AW-1:0]   sram_addr,
    output logic [BITW-1:0] sram_din,
    input  logic [BITW-1:0] sram_dout
);

    import bias_ctrl_pkg::*;

    state_t        r_state;
    logic [AW-1:0] r_wcnt;
    logic [AW-1:0] r_len;
    logic          r_loaded;
    logic          r_err;
    logic          r_vld_p1;
    logic          r_oor_p1;

    logic w_start_ok;
    logic w_start_bad;
    logic w_ld_fire;
    logic w_last;
    logic w_gnt;
    logic w_oor;

    function automatic logic len_legal(input logic [AW-1:0] len);
        return (len != '0) && (int'(len) <= WORDS);
    endfunction

    assign w_start_ok  = load_start &&  len_legal(load_len);
    assign w_start_bad = load_start && !len_legal(load_len);
    assign w_ld_fire   = (r_state == LOAD) && bus.ld_valid;
    assign w_last      = (r_wcnt == (r_len - 1'b1));
    // A load_start of any length blocks the grant so the restart always wins.
    assign w_gnt       = (r_state == READY) && bus.fetch_req && !load_start;
    assign w_oor       = (bus.fetch_ch >= r_len);

    assign bus.ld_ready   = (r_state == LOAD);
    assign bus.fetch_gnt  = w_gnt;
    assign bus.bias_valid = r_vld_p1;
    assign bus.bias_data  = (r_vld_p1 && !r_oor_p1) ? sram_dout : '0;
    assign busy           = (r_state == LOAD);
    assign loaded         = r_loaded;
    assign err            = r_err;

    always_comb begin
        sram_we   = 1'b0;
        sram_addr = '0;
        sram_din  = '0;
        if (w_ld_fire) begin
            sram_we   = 1'b1;
            sram_addr = r_wcnt;
            sram_din  = bus.ld_data;
        end else if (w_gnt) begin
            sram_addr = bus.fetch_ch;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_wcnt   <= '0;
            r_len    <= '0;
            r_loaded <= 1'b0;
            r_err    <= 1'b0;
        end else if (w_start_ok) begin
            r_state  <= LOAD;
            r_wcnt   <= '0;
            r_len    <= load_len;
            r_loaded <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            if (w_ld_fire) begin
                r_wcnt <= r_wcnt + 1'b1;
                if (w_last) begin
                    r_state  <= READY;
                    r_loaded <= 1'b1;
                end
            end
            if (w_gnt && w_oor) begin
                r_err <= 1'b1;
            end
            if (w_start_bad) begin
                r_err    <= 1'b1;
                r_loaded <= 1'b0;
            end
        end
    end

    // p0 = grant cycle (SRAM address phase), p1 = SRAM data phase / response
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld_p1 <= 1'b0;
            r_oor_p1 <= 1'b0;
        end else begin
            r_vld_p1 <= w_gnt;
            r_oor_p1 <= w_gnt && w_oor;
        end
    end

endmodule

// File: tb/tb_bias_sram_ctrl.sv
// Directed-vector bench for bias_sram_ctrl with a behavioural 1-cycle registered-read SRAM.
module tb_bias_sram_ctrl;

    import bias_ctrl_pkg::*;

    localparam int OW = 2 * BITW + AW + 7;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            load_start = 1'b0;
    logic [AW-1:0]   load_len = '0;
    logic            busy;
    logic            loaded;
    logic            err;
    logic            sram_we;
    logic [AW-1:0]   sram_addr;
    logic [BITW-1:0] sram_din;
    logic [BITW-1:0] sram_dout;

    int n_vec = 0;
    int n_err = 0;

    bias_sram_ctrl_if #(.AW(AW), .BITW(BITW)) bus ();

    bias_sram_ctrl #(.WORDS(WORDS), .BITW(BITW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_start (load_start),
        .load_len   (load_len),
        .bus        (bus),
        .busy       (busy),
        .loaded     (loaded),
        .err        (err),
        .sram_we    (sram_we),
        .sram_addr  (sram_addr),
        .sram_din   (sram_din),
        .sram_dout  (sram_dout)
    );

    always #5 clk = ~clk;

    logic [BITW-1:0] mem [64];
    always @(posedge clk) begin
        if (sram_we) mem[sram_addr] <= sram_din;
        sram_dout <= mem[sram_addr];
    end

    int              wr_n = 0;
    logic [AW-1:0]   wr_addr [256];
    logic [BITW-1:0] wr_data [256];
    always @(posedge clk) begin
        if (sram_we && wr_n < 256) begin
            wr_addr[wr_n] <= sram_addr;
            wr_data[wr_n] <= sram_din;
            wr_n          <= wr_n + 1;
        end
    end

    initial begin
        bus.ld_valid  = 1'b0;
        bus.ld_data   = '0;
        bus.fetch_req = 1'b0;
        bus.fetch_ch  = '0;
    end

    function automatic logic [OW-1:0] all_outs();
        return {bus.ld_ready, bus.fetch_gnt, bus.bias_valid, bus.bias_data,
                busy, loaded, err, sram_we, sram_addr, sram_din};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_load(input int len);
        load_start = 1'b1;
        load_len   = AW'(len);
        tick();
        load_start = 1'b0;
        load_len   = '0;
    endtask

    // gap != 0 drops ld_valid on every gap-th cycle
    task automatic stream(input int n, input int base, input int gap);
        int sent = 0;
        int cyc  = 0;
        while (sent < n && cyc < 400) begin
            if (gap != 0 && (cyc % gap) == gap - 1) begin
                bus.ld_valid = 1'b0;
            end else begin
                bus.ld_valid = 1'b1;
                bus.ld_data  = BITW'(base + sent);
            end
            #1;
            if (bus.ld_valid && bus.ld_ready) sent++;
            tick();
            cyc++;
        end
        bus.ld_valid = 1'b0;
        bus.ld_data  = '0;
        n_vec++;
        if (sent != n) begin
            n_err++;
            $display("FAIL stream_accept got=%0d words exp=%0d", sent, n);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_vec++;
        if (all_outs() !== '0) begin
            n_err++; $display("FAIL reset_during got=%h exp=0", all_outs());
        end
        rst_n = 1'b1;
        tick();
        n_vec++;
        if (all_outs() !== '0) begin
            n_err++; $display("FAIL reset_after got=%h exp=0", all_outs());
        end
    endtask

    task automatic test_illegal_idle();
        int base = wr_n;
        start_load(0);
        n_vec++;
        if ({err, busy, loaded} !== 3'b100) begin
            n_err++; $display("FAIL ill0_idle err/busy/loaded got=%b exp=100", {err, busy, loaded});
        end
        start_load(49);
        n_vec++;
        if ({err, busy, loaded} !== 3'b100) begin
            n_err++; $display("FAIL ill49_idle err/busy/loaded got=%b exp=100", {err, busy, loaded});
        end
        n_vec++;
        if (wr_n != base) begin
            n_err++; $display("FAIL ill_idle_writes got=%0d exp=0", wr_n - base);
        end
        bus.fetch_req = 1'b1;
        #1;
        n_vec++;
        if (bus.fetch_gnt !== 1'b0) begin
            n_err++; $display("FAIL idle_gnt got=%b exp=0", bus.fetch_gnt);
        end
        bus.fetch_req = 1'b0;
        tick();
    endtask

    task automatic test_load();
        int base = wr_n;
        int bad  = 0;
        start_load(48);
        n_vec++;
        if ({busy, bus.ld_ready, err, loaded} !== 4'b1100) begin
            n_err++; $display("FAIL load_start busy/rdy/err/loaded got=%b exp=1100",
                              {busy, bus.ld_ready, err, loaded});
        end
        stream(48, 0, 3);
        n_vec++;
        if ({loaded, busy, bus.ld_ready} !== 3'b100) begin
            n_err++; $display("FAIL load_done loaded/busy/rdy got=%b exp=100", {loaded, busy, bus.ld_ready});
        end
        n_vec++;
        if (wr_n - base != 48) begin
            n_err++; $display("FAIL load_wcount got=%0d exp=48", wr_n - base);
        end
        for (int i = 0; i < 48; i++) begin
            if (wr_addr[base + i] !== AW'(i) || wr_data[base + i] !== BITW'(i)) bad++;
        end
        n_vec++;
        if (bad != 0) begin
            n_err++; $display("FAIL load_addr_data got=%0d bad writes exp=0", bad);
        end
    endtask

    task automatic test_fetch();
        int chs [3] = '{5, 6, 47};
        for (int i = 0; i < 3; i++) begin
            bus.fetch_req = 1'b1;
            bus.fetch_ch  = AW'(chs[i]);
            #1;
            n_vec++;
            if ({bus.fetch_gnt, sram_we, sram_addr} !== {2'b10, AW'(chs[i])}) begin
                n_err++; $display("FAIL fetch_gnt%0d gnt/we/addr got=%b/%b/%0d exp=1/0/%0d",
                                  i, bus.fetch_gnt, sram_we, sram_addr, chs[i]);
            end
            tick();
            n_vec++;
            if (bus.bias_valid !== 1'b1 || bus.bias_data !== BITW'(chs[i])) begin
                n_err++; $display("FAIL fetch_rsp%0d got=%b/%h exp=1/%h",
                                  i, bus.bias_valid, bus.bias_data, chs[i]);
            end
        end
        bus.fetch_req = 1'b0;
        tick();
        n_vec++;
        if (bus.bias_valid !== 1'b0 || bus.bias_data !== '0) begin
            n_err++; $display("FAIL fetch_idle got=%b/%h exp=0/0", bus.bias_valid, bus.bias_data);
        end
    endtask

    task automatic test_range();
        start_load(10);
        stream(10, 'h100, 0);
        bus.fetch_req = 1'b1;
        bus.fetch_ch  = AW'(9);
        tick();
        n_vec++;
        if ({bus.bias_valid, bus.bias_data, err} !== {1'b1, 17'h00109, 1'b0}) begin
            n_err++; $display("FAIL range_ch9 v/d/err got=%b/%h/%b exp=1/00109/0",
                              bus.bias_valid, bus.bias_data, err);
        end
        bus.fetch_ch = AW'(12);
        #1;
        n_vec++;
        if (bus.fetch_gnt !== 1'b1) begin
            n_err++; $display("FAIL range_ch12_gnt got=%b exp=1", bus.fetch_gnt);
        end
        tick();
        bus.fetch_req = 1'b0;
        n_vec++;
        if ({bus.bias_valid, bus.bias_data, err} !== {1'b1, 17'h0, 1'b1}) begin
            n_err++; $display("FAIL range_ch12 v/d/err got=%b/%h/%b exp=1/00000/1",
                              bus.bias_valid, bus.bias_data, err);
        end
        tick();
        n_vec++;
        if ({err, bus.bias_valid} !== 2'b10) begin
            n_err++; $display("FAIL range_sticky err/v got=%b exp=10", {err, bus.bias_valid});
        end
        start_load(10);
        n_vec++;
        if ({err, busy} !== 2'b01) begin
            n_err++; $display("FAIL range_clear err/busy got=%b exp=01", {err, busy});
        end
        stream(10, 'h200, 2);
        n_vec++;
        if (loaded !== 1'b1) begin
            n_err++; $display("FAIL range_reload loaded got=%b exp=1", loaded);
        end
    endtask

    task automatic test_collision();
        bus.fetch_req = 1'b1;
        bus.fetch_ch  = AW'(3);
        tick();
        n_vec++;
        if (bus.bias_valid !== 1'b1 || bus.bias_data !== 17'h00203) begin
            n_err++; $display("FAIL coll_prior_rsp got=%b/%h exp=1/00203", bus.bias_valid, bus.bias_data);
        end
        load_start   = 1'b1;
        load_len     = AW'(10);
        bus.fetch_ch = AW'(4);
        #1;
        n_vec++;
        if (bus.fetch_gnt !== 1'b0) begin
            n_err++; $display("FAIL coll_gnt got=%b exp=0", bus.fetch_gnt);
        end
        tick();
        load_start    = 1'b0;
        load_len      = '0;
        bus.fetch_req = 1'b0;
        n_vec++;
        if ({busy, loaded, bus.bias_valid, bus.fetch_gnt} !== 4'b1000) begin
            n_err++; $display("FAIL coll_next busy/loaded/v/gnt got=%b exp=1000",
                              {busy, loaded, bus.bias_valid, bus.fetch_gnt});
        end
        stream(10, 'h300, 0);
        n_vec++;
        if ({loaded, busy} !== 2'b10) begin
            n_err++; $display("FAIL coll_reload loaded/busy got=%b exp=10", {loaded, busy});
        end
    endtask

    task automatic test_illegal_ready();
        int base = wr_n;
        start_load(0);
        n_vec++;
        if ({err, busy, loaded, bus.ld_ready} !== 4'b1000) begin
            n_err++; $display("FAIL ill0_ready err/busy/loaded/rdy got=%b exp=1000",
                              {err, busy, loaded, bus.ld_ready});
        end
        start_load(49);
        n_vec++;
        if ({err, busy} !== 2'b10) begin
            n_err++; $display("FAIL ill49_ready err/busy got=%b exp=10", {err, busy});
        end
        n_vec++;
        if (wr_n != base) begin
            n_err++; $display("FAIL ill_ready_writes got=%0d exp=0", wr_n - base);
        end
        bus.fetch_req = 1'b1;
        bus.fetch_ch  = AW'(2);
        #1;
        n_vec++;
        if (bus.fetch_gnt !== 1'b1) begin
            n_err++; $display("FAIL ill_ready_gnt got=%b exp=1", bus.fetch_gnt);
        end
        tick();
        bus.fetch_req = 1'b0;
        n_vec++;
        if (bus.bias_data !== 17'h00302) begin
            n_err++; $display("FAIL ill_ready_rsp got=%h exp=00302", bus.bias_data);
        end
        tick();
    endtask

    task automatic test_reset_midload();
        int base;
        start_load(48);
        base = wr_n;
        stream(20, 'h400, 0);
        rst_n = 1'b0;
        #1;
        n_vec++;
        if (all_outs() !== '0) begin
            n_err++; $display("FAIL rst_mid_outs got=%h exp=0", all_outs());
        end
        n_vec++;
        if (wr_n - base != 20) begin
            n_err++; $display("FAIL rst_mid_wcount got=%0d exp=20", wr_n - base);
        end
        tick();
        rst_n         = 1'b1;
        bus.ld_valid  = 1'b1;
        bus.ld_data   = 17'h1ffff;
        bus.fetch_req = 1'b1;
        bus.fetch_ch  = '0;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_vec++;
            if ({bus.fetch_gnt, bus.ld_ready, sram_we, busy} !== 4'b0000) begin
                n_err++; $display("FAIL rst_post%0d gnt/rdy/we/busy got=%b exp=0000",
                                  i, {bus.fetch_gnt, bus.ld_ready, sram_we, busy});
            end
            tick();
        end
        bus.ld_valid  = 1'b0;
        bus.fetch_req = 1'b0;
        start_load(2);
        stream(2, 'h500, 0);
        bus.fetch_req = 1'b1;
        bus.fetch_ch  = AW'(1);
        #1;
        n_vec++;
        if (bus.fetch_gnt !== 1'b1) begin
            n_err++; $display("FAIL rst_newload_gnt got=%b exp=1", bus.fetch_gnt);
        end
        tick();
        bus.fetch_req = 1'b0;
        n_vec++;
        if (bus.bias_valid !== 1'b1 || bus.bias_data !== 17'h00501) begin
            n_err++; $display("FAIL rst_newload_rsp got=%b/%h exp=1/00501", bus.bias_valid, bus.bias_data);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_illegal_idle();
        test_load();
        test_fetch();
        test_range();
        test_collision();
        test_illegal_ready();
        test_reset_midload();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

endmodule
